// File: rtl/el2_ic_tag_array.sv
// el2_ic_tag_array: N-way instruction-cache tag array with per-way valid bits,
// registered hit/parity-error lookup, a one-set-per-cycle flush sequencer and
// a registered debug read/write port.
// Optional macro: EL2_ICACHE_TAG_PARITY_EN enables tag parity storage/checking.
module el2_ic_tag_array #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 29,
  parameter int unsigned IDX_LO = 3,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned TAG_W = ADDR_W - IDX_LO - IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ic_rw_addr,
  input  logic              ic_rd_en,
  input  logic [WAYS-1:0]   ic_wr_en,
  input  logic [WAYS-1:0]   ic_tag_valid,
  input  logic              dec_tlu_core_ecc_disable,
  input  logic              ic_flush_all,
  output logic              ic_flush_busy,
  input  logic [IDX_W-1:0]  ic_debug_addr,
  input  logic [WAYS-1:0]   ic_debug_way,
  input  logic              ic_debug_rd_en,
  input  logic              ic_debug_wr_en,
  input  logic [TAG_W+1:0]  ic_debug_wr_data,
  output logic [TAG_W+1:0]  ictag_debug_rd_data,
  output logic              ictag_debug_rd_valid,
  output logic [WAYS-1:0]   ic_rd_hit,
  output logic              ic_tag_perr
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           flush_cnt_q, flush_cnt_d;
  logic                       busy;

  logic [DEPTH-1:0][WAYS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]           tag_mem [WAYS][DEPTH];

  logic [IDX_W-1:0]           addr_idx;
  logic [TAG_W-1:0]           addr_tag;
  logic [WAYS-1:0]            dbg_sel;

  logic [WAYS-1:0]            wr_we;
  logic [IDX_W-1:0]           wr_idx;
  logic [TAG_W-1:0]           wr_tag;
  logic [WAYS-1:0]            wr_vld;

  logic [WAYS-1:0]            hit_c;
  logic                       perr_c;
  logic [TAG_W+1:0]           dbg_rd_c;

  logic [WAYS-1:0]            rd_hit_q, rd_hit_d;
  logic                       tag_perr_q, tag_perr_d;
  logic [TAG_W+1:0]           dbg_rd_data_q, dbg_rd_data_d;
  logic                       dbg_rd_valid_q, dbg_rd_valid_d;

  logic                       unused_addr_lo;

`ifdef EL2_ICACHE_TAG_PARITY_EN
  logic [WAYS-1:0]            par_mem [DEPTH];
  logic                       wr_par;
`else
  logic                       unused_dbg_par;
  assign unused_dbg_par = ic_debug_wr_data[TAG_W+1];
`endif

  assign unused_addr_lo = ^ic_rw_addr[IDX_LO-1:0];

  assign busy     = (state_q == FLUSH);
  assign addr_idx = ic_rw_addr[IDX_LO +: IDX_W];
  assign addr_tag = ic_rw_addr[ADDR_W-1 -: TAG_W];
  // Isolate the lowest set bit of the debug way select
  assign dbg_sel  = ic_debug_way & (~ic_debug_way + WAYS'(1));

  // Flush sequencer: walk every set once; a new flush request restarts the walk
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (ic_flush_all) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (ic_flush_all) begin
          flush_cnt_d = '0;
        end else if (flush_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write arbitration: debug write beats fill; both are dropped while flushing
  always_comb begin
    wr_we  = '0;
    wr_idx = addr_idx;
    wr_tag = addr_tag;
    wr_vld = ic_tag_valid;
`ifdef EL2_ICACHE_TAG_PARITY_EN
    wr_par = ^addr_tag;
`endif
    if (!busy) begin
      if (ic_debug_wr_en) begin
        wr_we  = dbg_sel;
        wr_idx = ic_debug_addr;
        wr_tag = ic_debug_wr_data[TAG_W-1:0];
        wr_vld = {WAYS{ic_debug_wr_data[TAG_W]}};
`ifdef EL2_ICACHE_TAG_PARITY_EN
        wr_par = ic_debug_wr_data[TAG_W+1];
`endif
      end else begin
        wr_we = ic_wr_en;
      end
    end
  end

  // Valid-bit next state: flush clears one set per cycle, otherwise apply writes
  always_comb begin
    valid_d = valid_q;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (busy) begin
        valid_d[flush_cnt_q][w] = 1'b0;
      end else if (wr_we[w]) begin
        valid_d[wr_idx][w] = wr_vld[w];
      end
    end
  end

  // Tag lookup and parity check against pre-write contents
  always_comb begin
    hit_c  = '0;
    perr_c = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_c[w] = valid_q[addr_idx][w] & (tag_mem[w][addr_idx] == addr_tag);
`ifdef EL2_ICACHE_TAG_PARITY_EN
      perr_c = perr_c | (valid_q[addr_idx][w] &
                         (par_mem[addr_idx][w] != ^tag_mem[w][addr_idx]));
`endif
    end
  end

  // Debug read mux: selected way only, zero when no way is selected
  always_comb begin
    dbg_rd_c = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (dbg_sel[w]) begin
`ifdef EL2_ICACHE_TAG_PARITY_EN
        dbg_rd_c = dbg_rd_c | {par_mem[ic_debug_addr][w], valid_q[ic_debug_addr][w],
                               tag_mem[w][ic_debug_addr]};
`else
        dbg_rd_c = dbg_rd_c | {1'b0, valid_q[ic_debug_addr][w], tag_mem[w][ic_debug_addr]};
`endif
      end
    end
  end

  // Output register next state: lookup results hold until the next lookup
  always_comb begin
    rd_hit_d       = rd_hit_q;
    tag_perr_d     = tag_perr_q;
    dbg_rd_data_d  = dbg_rd_data_q;
    dbg_rd_valid_d = ic_debug_rd_en;
    if (ic_rd_en) begin
      rd_hit_d   = busy ? '0 : hit_c;
      tag_perr_d = ~busy & perr_c & ~dec_tlu_core_ecc_disable;
    end
    if (ic_debug_rd_en) begin
      dbg_rd_data_d = dbg_rd_c;
    end
  end

  // Resettable state: FSM, valid bits and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      flush_cnt_q    <= '0;
      valid_q        <= '0;
      rd_hit_q       <= '0;
      tag_perr_q     <= 1'b0;
      dbg_rd_data_q  <= '0;
      dbg_rd_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      valid_q        <= valid_d;
      rd_hit_q       <= rd_hit_d;
      tag_perr_q     <= tag_perr_d;
      dbg_rd_data_q  <= dbg_rd_data_d;
      dbg_rd_valid_q <= dbg_rd_valid_d;
    end
  end

  // Tag/parity storage is not reset
  always_ff @(posedge clock) begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (wr_we[w]) begin
        tag_mem[w][wr_idx] <= wr_tag;
`ifdef EL2_ICACHE_TAG_PARITY_EN
        par_mem[wr_idx][w] <= wr_par;
`endif
      end
    end
  end

  assign ic_flush_busy        = busy;
  assign ic_rd_hit            = rd_hit_q;
  assign ic_tag_perr          = tag_perr_q;
  assign ictag_debug_rd_data  = dbg_rd_data_q;
  assign ictag_debug_rd_valid = dbg_rd_valid_q;

endmodule

// File: tb/tb_el2_ic_tag_array.sv
// Scoreboard bench for el2_ic_tag_array: stimulus pushes expected lookup and
// debug-read responses; a monitor pops and compares when the DUT responds.
module tb_el2_ic_tag_array;

  localparam int WAYS   = 2;
  localparam int ADDR_W = 29;
  localparam int IDX_W  = 7;
  localparam int TAG_W  = 19;
`ifdef EL2_ICACHE_TAG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] ic_rw_addr = '0;
  logic              ic_rd_en = 1'b0;
  logic [WAYS-1:0]   ic_wr_en = '0;
  logic [WAYS-1:0]   ic_tag_valid = '0;
  logic              dec_tlu_core_ecc_disable = 1'b0;
  logic              ic_flush_all = 1'b0;
  logic              ic_flush_busy;
  logic [IDX_W-1:0]  ic_debug_addr = '0;
  logic [WAYS-1:0]   ic_debug_way = '0;
  logic              ic_debug_rd_en = 1'b0;
  logic              ic_debug_wr_en = 1'b0;
  logic [TAG_W+1:0]  ic_debug_wr_data = '0;
  logic [TAG_W+1:0]  ictag_debug_rd_data;
  logic              ictag_debug_rd_valid;
  logic [WAYS-1:0]   ic_rd_hit;
  logic              ic_tag_perr;

  el2_ic_tag_array #(.WAYS(WAYS), .DEPTH(128), .ADDR_W(ADDR_W), .IDX_LO(3)) dut (
    .clock(clock), .reset(reset), .ic_rw_addr(ic_rw_addr), .ic_rd_en(ic_rd_en),
    .ic_wr_en(ic_wr_en), .ic_tag_valid(ic_tag_valid),
    .dec_tlu_core_ecc_disable(dec_tlu_core_ecc_disable), .ic_flush_all(ic_flush_all),
    .ic_flush_busy(ic_flush_busy), .ic_debug_addr(ic_debug_addr), .ic_debug_way(ic_debug_way),
    .ic_debug_rd_en(ic_debug_rd_en), .ic_debug_wr_en(ic_debug_wr_en),
    .ic_debug_wr_data(ic_debug_wr_data), .ictag_debug_rd_data(ictag_debug_rd_data),
    .ictag_debug_rd_valid(ictag_debug_rd_valid), .ic_rd_hit(ic_rd_hit), .ic_tag_perr(ic_tag_perr)
  );

  always #5 clock = ~clock;

  typedef struct { logic [WAYS-1:0] hit; logic perr; string nm; } lk_t;
  typedef struct { logic [TAG_W+1:0] data; string nm; } dr_t;
  lk_t lkq[$];
  dr_t drq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a lookup accepted at a posedge is answered by the next negedge
  logic lk_pend = 1'b0;
  always @(posedge clock) lk_pend <= ic_rd_en && reset;

  always @(negedge clock) begin
    lk_t e;
    dr_t d;
    if (lk_pend) begin
      if (lkq.size() == 0) chk("lookup_unexpected", 32'd1, 32'd0);
      else begin
        e = lkq.pop_front();
        chk({e.nm, "_hit"}, 32'(ic_rd_hit), 32'(e.hit));
        chk({e.nm, "_perr"}, 32'(ic_tag_perr), 32'(e.perr));
      end
    end
    if (ictag_debug_rd_valid) begin
      if (drq.size() == 0) chk("dbg_rd_valid_unexpected", 32'd1, 32'd0);
      else begin
        d = drq.pop_front();
        chk(d.nm, 32'(ictag_debug_rd_data), 32'(d.data));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_drives();
    ic_rd_en = 1'b0; ic_wr_en = '0; ic_tag_valid = '0; ic_debug_wr_en = 1'b0;
    ic_debug_rd_en = 1'b0; ic_flush_all = 1'b0; dec_tlu_core_ecc_disable = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] mk(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx);
    return {tag, idx, 3'b000};
  endfunction

  task automatic lookup(input logic [ADDR_W-1:0] a, input logic [WAYS-1:0] h, input logic p,
                        input logic ecc_dis, input string nm);
    lk_t e;
    e.hit = h; e.perr = p; e.nm = nm;
    lkq.push_back(e);
    ic_rw_addr = a; ic_rd_en = 1'b1; dec_tlu_core_ecc_disable = ecc_dis;
    step();
    clear_drives();
  endtask

  task automatic fill(input logic [ADDR_W-1:0] a, input logic [WAYS-1:0] we, input logic [WAYS-1:0] vld);
    ic_rw_addr = a; ic_wr_en = we; ic_tag_valid = vld;
    step();
    clear_drives();
  endtask

  task automatic dbg_wr(input logic [IDX_W-1:0] idx, input logic [WAYS-1:0] way, input logic [TAG_W+1:0] data);
    ic_debug_addr = idx; ic_debug_way = way; ic_debug_wr_data = data; ic_debug_wr_en = 1'b1;
    step();
    clear_drives();
  endtask

  task automatic dbg_rd(input logic [IDX_W-1:0] idx, input logic [WAYS-1:0] way,
                        input logic [TAG_W+1:0] exp, input string nm);
    dr_t d;
    d.data = exp; d.nm = nm;
    drq.push_back(d);
    ic_debug_addr = idx; ic_debug_way = way; ic_debug_rd_en = 1'b1;
    step();
    clear_drives();
  endtask

  logic [TAG_W-1:0] ta, t5, t7, t9, t20, t21, t30, t100;
  logic [TAG_W+1:0] dbg5;
  int busy_cnt;

  // Pulse flush and count busy cycles; optional mid-flush activity and restart
  task automatic run_flush(input int restart_at, input bit extras, output int cnt);
    lk_t e;
    dr_t d;
    ic_flush_all = 1'b1;
    step();
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      clear_drives();
      if (!ic_flush_busy) break;
      cnt++;
      if (k == restart_at) ic_flush_all = 1'b1;
      if (extras && k == 1) begin
        d.data = dbg5; d.nm = "dbg_rd_during_flush";
        drq.push_back(d);
        ic_debug_addr = 7'd5; ic_debug_way = 2'b01; ic_debug_rd_en = 1'b1;
      end
      if (extras && k == 3) begin
        e.hit = 2'b00; e.perr = 1'b0; e.nm = "lookup_during_flush";
        lkq.push_back(e);
        ic_rw_addr = mk(t7, 7'd7); ic_rd_en = 1'b1;
      end
      if (extras && k == 100) begin
        ic_rw_addr = mk(t20, 7'd20); ic_wr_en = 2'b01; ic_tag_valid = 2'b01;
      end
      if (extras && k == 101) begin
        ic_debug_addr = 7'd21; ic_debug_way = 2'b10; ic_debug_wr_en = 1'b1;
        ic_debug_wr_data = {^t21, 1'b1, t21};
      end
      step();
    end
    clear_drives();
  endtask

  initial begin
    ta = 19'h2AF37; t5 = 19'h5A5A5; t7 = 19'h00777; t9 = 19'h00999;
    t20 = 19'h12020; t21 = 19'h12121; t30 = 19'h03030; t100 = 19'h10100;
    dbg5 = {~(^t5), 1'b1, t5};

    // Reset state
    repeat (2) step();
    chk("reset_hit", 32'(ic_rd_hit), 32'd0);
    chk("reset_perr", 32'(ic_tag_perr), 32'd0);
    chk("reset_busy", 32'(ic_flush_busy), 32'd0);
    chk("reset_dbg_valid", 32'(ictag_debug_rd_valid), 32'd0);
    chk("reset_dbg_data", 32'(ictag_debug_rd_data), 32'd0);
    reset = 1'b1;
    step();

    lookup(29'h0ABCDE08, 2'b00, 1'b0, 1'b0, "lookup_after_reset");

    // Fill way1 and look up matching / non-matching tags
    fill(29'h0ABCDE08, 2'b10, 2'b10);
    lookup(29'h0ABCDE08, 2'b10, 1'b0, 1'b0, "lookup_way1_hit");
    step();
    chk("hit_held", 32'(ic_rd_hit), 32'h2);
    lookup(mk(ta ^ 19'h1, 7'd65), 2'b00, 1'b0, 1'b0, "lookup_other_tag");

    // Debug write with inverted parity into way0 idx5
    dbg_wr(7'd5, 2'b01, dbg5);
    lookup(mk(t5, 7'd5), 2'b01, PAR, 1'b0, "lookup_bad_parity");
    lookup(mk(t5, 7'd5), 2'b01, 1'b0, 1'b1, "lookup_ecc_disabled");

    // Debug reads: written entry, lowest-way select, no way, filled entry
    dbg_rd(7'd5, 2'b01, {PAR & ~(^t5), 1'b1, t5}, "dbg_rd_way0_idx5");
    dbg_rd(7'd5, 2'b11, {PAR & ~(^t5), 1'b1, t5}, "dbg_rd_lowest_way");
    dbg_rd(7'd5, 2'b00, '0, "dbg_rd_no_way");
    dbg_rd(7'd65, 2'b10, {PAR & (^ta), 1'b1, ta}, "dbg_rd_filled_way1");

    // Both ways at idx7, then a flush with dropped writes mid-flush
    fill(mk(t7, 7'd7), 2'b11, 2'b11);
    lookup(mk(t7, 7'd7), 2'b11, 1'b0, 1'b0, "lookup_both_ways");
    dbg5 = {PAR & ~(^t5), 1'b1, t5};
    run_flush(-1, 1'b1, busy_cnt);
    chk("flush_busy_cycles", 32'(busy_cnt), 32'd128);
    lookup(mk(t7, 7'd7), 2'b00, 1'b0, 1'b0, "lookup_idx7_after_flush");
    lookup(mk(t20, 7'd20), 2'b00, 1'b0, 1'b0, "fill_dropped_while_busy");
    lookup(mk(t21, 7'd21), 2'b00, 1'b0, 1'b0, "dbg_wr_dropped_while_busy");
    lookup(29'h0ABCDE08, 2'b00, 1'b0, 1'b0, "lookup_idx65_after_flush");
    lookup(mk(t5, 7'd5), 2'b00, 1'b0, 1'b0, "lookup_idx5_after_flush");

    // Restart of the flush walk
    run_flush(10, 1'b0, busy_cnt);
    chk("flush_restart_cycles", 32'(busy_cnt), 32'd139);

    // Same-cycle fill and lookup returns pre-write contents
    ic_rw_addr = mk(t9, 7'd9); ic_wr_en = 2'b01; ic_tag_valid = 2'b01;
    lookup(mk(t9, 7'd9), 2'b00, 1'b0, 1'b0, "same_cycle_fill_lookup");
    lookup(mk(t9, 7'd9), 2'b01, 1'b0, 1'b0, "lookup_after_fill");

    // Reset in the middle of a flush
    fill(mk(t30, 7'd30), 2'b01, 2'b01);
    fill(mk(t100, 7'd100), 2'b10, 2'b10);
    lookup(mk(t30, 7'd30), 2'b01, 1'b0, 1'b0, "lookup_idx30_pre");
    lookup(mk(t100, 7'd100), 2'b10, 1'b0, 1'b0, "lookup_idx100_pre");
    ic_flush_all = 1'b1;
    step();
    clear_drives();
    repeat (4) step();
    chk("busy_before_reset", 32'(ic_flush_busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("busy_cleared_by_reset", 32'(ic_flush_busy), 32'd0);
    chk("hit_cleared_by_reset", 32'(ic_rd_hit), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("busy_after_reset_release", 32'(ic_flush_busy), 32'd0);
    lookup(mk(t30, 7'd30), 2'b00, 1'b0, 1'b0, "lookup_idx30_post_reset");
    lookup(mk(t100, 7'd100), 2'b00, 1'b0, 1'b0, "lookup_idx100_post_reset");

    repeat (3) step();
    chk("lookup_queue_drained", 32'(lkq.size()), 32'd0);
    chk("dbg_queue_drained", 32'(drq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
